dual_core_sp_ram_arbiter: RTL and testbench
===========================================

// Module: dual_core_sp_ram_arbiter
// PURPOSE
//  Shares one single-port RAM between the data ports of two cores in the fault-tolerant SoC.
//  Per-core OBI-style req/gnt/rvalid ports; round-robin arbitration; one RAM access per cycle.
//  Tracks the owner of each RAM response and steers rvalid back to that core.
// PARAMETERS
//  ADDR_WIDTH  32  byte address width of the core ports
//  DATA_WIDTH  32  data width; BE width = DATA_WIDTH/8
//  RAM_AW      12  RAM word-address width; ram_addr_o = addr_i[k][RAM_AW+1:2]
//  CNT_WIDTH   8   width of the saturating mismatch counter
// PORTS
//  clk_i        in   1            clock
//  rst_i        in   1            synchronous reset, active-high
//  req_i        in   2            per-core request
//  gnt_o        out  2            per-core grant (combinational, same cycle as req)
//  addr_i       in   2xADDR_WIDTH per-core byte address
//  we_i         in   2            per-core write enable
//  be_i         in   2xDATA/8     per-core byte enables
//  wdata_i      in   2xDATA_WIDTH per-core write data
//  rvalid_o     out  2            per-core response valid, 1 cycle after gnt
//  rdata_o      out  DATA_WIDTH   response data (shared by both cores; qualified by rvalid_o[k])
//  ram_en_o     out  1            RAM access strobe
//  ram_we_o     out  1            RAM write enable
//  ram_addr_o   out  RAM_AW       RAM word address
//  ram_be_o     out  DATA/8       RAM byte enables
//  ram_wdata_o  out  DATA_WIDTH   RAM write data
//  ram_rdata_i  in   DATA_WIDTH   RAM read data, valid 1 cycle after ram_en_o
//  mismatch_o   out  1            lockstep mismatch pulse
//  err_cnt_o    out  CNT_WIDTH    saturating mismatch count
// BEHAVIOUR
//  - Reset: gnt_o=0, rvalid_o=0, ram_en_o=0, mismatch_o=0, err_cnt_o=0, prio_q=core0, owner_q=none.
//  - Only req_i[0] high: grant core0. Only req_i[1] high: grant core1. prio_q unchanged.
//  - Both high: grant core prio_q; prio_q toggles to the other core. The loser holds req (OBI rule).
//  - Exactly one RAM access per granted cycle: ram_en_o = |gnt_o. Ram fields are muxed from the granted core.
//  - owner_q[k] <= gnt_o[k] every cycle. rvalid_o = owner_q. rdata_o = ram_rdata_i.
//  - Read and write latency is 1 cycle. Writes also return rvalid; rdata_o is don't-care for writes.
//  - Back-to-back: a new grant can coexist with the previous rvalid, giving full throughput.
//  - Address bits above RAM_AW+1 are ignored, so addresses wrap modulo RAM size.
//  - Reset asserted mid-access: the pending rvalid is dropped and the RAM access is abandoned.
//  - Deassertion of req_i without a grant is a protocol violation; an assertion flags it, no RTL recovery.
// CONFIGURATION
//  LOCKSTEP_MERGE_EN defined:
//   - Both cores request with equal addr/we/be (and wdata when we=1): grant both.
//   - One RAM access serves both; rvalid on both next cycle; prio_q unchanged.
//   - Both request with any mismatch: mismatch_o=1 for that cycle; err_cnt_o increments, saturating at all-ones.
//   - A mismatched pair is then arbitrated round-robin as normal.
//  LOCKSTEP_MERGE_EN undefined:
//   - Pure round-robin; no merging.
//   - mismatch_o and err_cnt_o are tied to 0.
// STRUCTURE
//  - Package sp_ram_arb_pkg holds:
//    - core_id_e enum (CORE0, CORE1)
//    - mem_req_t struct {addr, we, be, wdata}
//    - function word_addr() for the address slice
//  - Sub-module rr_arb2: 2-way round-robin arbiter with the prio_q register.
//  - Top level holds the request mux, owner_q, merge compare and err counter.
// TESTING
//  1. Reset, then core0 writes 0xDEADBEEF at 0x10, reads 0x10 -> ram_addr_o=4; rvalid_o=01 next cycle; rdata_o=0xDEADBEEF.
//  2. Both request continuously, distinct addresses -> gnt_o alternates 01,10,01,10; every rvalid lands 1 cycle after its gnt.
//  3. Merge on: both read 0x20 identically -> gnt_o=11, one ram_en_o pulse, rvalid_o=11; err_cnt_o stays 0.
//  4. Merge on: both write 0x20, wdata 0x1 vs 0x2 -> mismatch_o pulses once, err_cnt_o=1; two sequential RAM writes.
//  5. 300 forced mismatches with CNT_WIDTH=8 -> err_cnt_o saturates at 255.
//  6. rst_i asserted the cycle after a grant -> rvalid_o=00 next cycle; after release, prio_q=core0 (both req -> gnt_o=01).

Source files
------------

// File: rtl/dual_core_sp_ram_arbiter_pkg.sv
// Shared types and helpers for the dual-core single-port RAM arbiter.
// Optional feature macro used by the arbiter top: LOCKSTEP_MERGE_EN.
package sp_ram_arb_pkg;

    typedef enum logic {
        CORE0 = 1'b0,
        CORE1 = 1'b1
    } core_id_e;

    localparam int unsigned PKG_ADDR_W = 32;
    localparam int unsigned PKG_DATA_W = 32;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0]   addr;
        logic                    we;
        logic [PKG_DATA_W/8-1:0] be;
        logic [PKG_DATA_W-1:0]   wdata;
    } mem_req_t;

    // Byte address to word address; the caller truncates to the RAM depth,
    // which is what makes addresses wrap modulo the RAM size.
    function automatic logic [PKG_ADDR_W-1:0] word_addr(input logic [PKG_ADDR_W-1:0] byte_addr);
        return {2'b00, byte_addr[PKG_ADDR_W-1:2]};
    endfunction

endpackage

// File: rtl/dual_core_sp_ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer only moves when both
// cores contend and are not merged into a single access.
module rr_arb2
    import sp_ram_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       merge_i,
    output logic [1:0] gnt_o
);

    core_id_e r_prio;

    // Grant decode from the request pattern and current priority
    always_comb begin
        gnt_o = 2'b00;
        if (rst_i) begin
            gnt_o = 2'b00;
        end else begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = merge_i ? 2'b11 : ((r_prio == CORE0) ? 2'b01 : 2'b10);
                default: gnt_o = 2'b00;
            endcase
        end
    end

    // Priority pointer: hand priority to the loser after a contended grant
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio <= CORE0;
        end else if ((req_i == 2'b11) && !merge_i) begin
            r_prio <= (r_prio == CORE0) ? CORE1 : CORE0;
        end else begin
            r_prio <= r_prio;
        end
    end

endmodule

// File: rtl/dual_core_sp_ram_arbiter.sv
// Shares one single-port RAM between two OBI-style core data ports.
// Define LOCKSTEP_MERGE_EN to merge identical lockstep requests and count mismatches.
module dual_core_sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RAM_AW     = 12,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [1:0]                     req_i,
    output logic [1:0]                     gnt_o,
    input  logic [1:0][ADDR_WIDTH-1:0]     addr_i,
    input  logic [1:0]                     we_i,
    input  logic [1:0][DATA_WIDTH/8-1:0]   be_i,
    input  logic [1:0][DATA_WIDTH-1:0]     wdata_i,
    output logic [1:0]                     rvalid_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           ram_en_o,
    output logic                           ram_we_o,
    output logic [RAM_AW-1:0]              ram_addr_o,
    output logic [DATA_WIDTH/8-1:0]        ram_be_o,
    output logic [DATA_WIDTH-1:0]          ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]          ram_rdata_i,
    output logic                           mismatch_o,
    output logic [CNT_WIDTH-1:0]           err_cnt_o
);

    mem_req_t   w_req [2];
    mem_req_t   w_sel;
    logic [1:0] w_gnt;
    logic       w_merge;
    logic [1:0] r_owner;

    // Gather each core's request fields into the common request struct
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_req[k].addr  = PKG_ADDR_W'(addr_i[k]);
            w_req[k].we    = we_i[k];
            w_req[k].be    = (PKG_DATA_W/8)'(be_i[k]);
            w_req[k].wdata = PKG_DATA_W'(wdata_i[k]);
        end
    end

`ifdef LOCKSTEP_MERGE_EN
    logic                 w_same;
    logic                 w_mismatch;
    logic [CNT_WIDTH-1:0] r_err_cnt;

    // Write data only matters for the comparison when the pair is a write
    assign w_same = (w_req[0].addr == w_req[1].addr) &&
                    (w_req[0].we   == w_req[1].we)   &&
                    (w_req[0].be   == w_req[1].be)   &&
                    (!w_req[0].we || (w_req[0].wdata == w_req[1].wdata));

    assign w_merge    = (req_i == 2'b11) && w_same  && !rst_i;
    assign w_mismatch = (req_i == 2'b11) && !w_same && !rst_i;

    // Saturating lockstep mismatch counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_cnt <= {CNT_WIDTH{1'b0}};
        end else if (w_mismatch && (r_err_cnt != {CNT_WIDTH{1'b1}})) begin
            r_err_cnt <= r_err_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

    assign mismatch_o = w_mismatch;
    assign err_cnt_o  = r_err_cnt;
`else
    assign w_merge    = 1'b0;
    assign mismatch_o = 1'b0;
    assign err_cnt_o  = {CNT_WIDTH{1'b0}};
`endif

    rr_arb2 u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .merge_i (w_merge),
        .gnt_o   (w_gnt)
    );

    // A merged pair is identical, so core0's fields serve both cores
    assign w_sel       = (w_gnt == 2'b10) ? w_req[1] : w_req[0];
    assign gnt_o       = w_gnt;
    assign ram_en_o    = |w_gnt;
    assign ram_we_o    = ram_en_o & w_sel.we;
    assign ram_addr_o  = RAM_AW'(word_addr(w_sel.addr));
    assign ram_be_o    = (DATA_WIDTH/8)'(w_sel.be);
    assign ram_wdata_o = DATA_WIDTH'(w_sel.wdata);

    // Response owner tracking; reset drops any in-flight response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_owner <= 2'b00;
        end else begin
            r_owner <= w_gnt;
        end
    end

    assign rvalid_o = r_owner;
    assign rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_dual_core_sp_ram_arbiter.sv
// Directed self-checking bench for dual_core_sp_ram_arbiter with a 1-cycle RAM model.
// Merge scenarios run only when LOCKSTEP_MERGE_EN is defined.
module tb_dual_core_sp_ram_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req, we, gnt, rvalid;
    logic [1:0][31:0] addr, wdata;
    logic [1:0][3:0]  be;
    logic [31:0]      rdata, ram_wdata, ram_rdata;
    logic             ram_en, ram_we, mismatch;
    logic [11:0]      ram_addr;
    logic [3:0]       ram_be;
    logic [7:0]       err_cnt;
    logic [31:0]      mem [4096];
    int               total = 0;
    int               bad = 0;

    always #5 clk = ~clk;

    dual_core_sp_ram_arbiter dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_be_o(ram_be),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .mismatch_o(mismatch),
        .err_cnt_o(err_cnt)
    );

    // Single-port RAM model with byte enables and 1-cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic idle();
        req = 2'b00; we = 2'b00; be = '0; addr = '0; wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        repeat (2) @(negedge clk);
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rst_gnt: got %b want 00", gnt); end
        total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL rst_ram_en: got %b want 0", ram_en); end
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL rst_rvalid: got %b want 00", rvalid); end
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL rst_mismatch: got %b want 0", mismatch); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
        req = 2'b11; addr[0] = 32'h100; addr[1] = 32'h200; #1;
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rst_req_gnt: got %b want 00", gnt); end
        total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL rst_req_en: got %b want 0", ram_en); end
        @(negedge clk); idle(); rst = 1'b0;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        req = 2'b01; addr[0] = 32'h10; we[0] = 1'b1; be[0] = 4'hF; wdata[0] = 32'hDEADBEEF; #1;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL wr_gnt: got %b want 01", gnt); end
        total++; if (ram_en !== 1'b1 || ram_we !== 1'b1) begin bad++; $display("FAIL wr_en_we: got %b%b want 11", ram_en, ram_we); end
        total++; if (ram_addr !== 12'd4) begin bad++; $display("FAIL wr_addr: got %h want 004", ram_addr); end
        total++; if (ram_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_wdata: got %h want deadbeef", ram_wdata); end
        total++; if (ram_be !== 4'hF) begin bad++; $display("FAIL wr_be: got %h want f", ram_be); end
        @(negedge clk);
        total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL wr_rvalid: got %b want 01", rvalid); end
        we[0] = 1'b0; #1;
        total++; if (gnt !== 2'b01 || ram_we !== 1'b0 || ram_addr !== 12'd4) begin bad++; $display("FAIL rd_req: got gnt=%b we=%b addr=%h want 01 0 004", gnt, ram_we, ram_addr); end
        @(negedge clk);
        total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL rd_rvalid: got %b want 01", rvalid); end
        total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata: got %h want deadbeef", rdata); end
        idle(); req = 2'b10; addr[1] = 32'h4014; #1;
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL wrap_gnt: got %b want 10", gnt); end
        total++; if (ram_addr !== 12'h005) begin bad++; $display("FAIL wrap_addr: got %h want 005", ram_addr); end
        @(negedge clk);
        total++; if (rvalid !== 2'b10) begin bad++; $display("FAIL wrap_rvalid: got %b want 10", rvalid); end
        idle();
        @(negedge clk);
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL idle_rvalid: got %b want 00", rvalid); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_g;
        logic [1:0]  prev_g;
        logic [11:0] exp_a;
        prev_g = 2'b00;
        req = 2'b11; addr[0] = 32'h100; addr[1] = 32'h200; be = '1;
        for (int i = 0; i < 4; i++) begin
            exp_g = ((i % 2) == 0) ? 2'b01 : 2'b10;
            exp_a = (exp_g == 2'b01) ? 12'h040 : 12'h080;
            #1;
            total++; if (gnt !== exp_g) begin bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, exp_g); end
            total++; if (ram_addr !== exp_a) begin bad++; $display("FAIL rr_addr[%0d]: got %h want %h", i, ram_addr, exp_a); end
            if (i > 0) begin
                total++; if (rvalid !== prev_g) begin bad++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, rvalid, prev_g); end
            end
`ifndef LOCKSTEP_MERGE_EN
            total++; if (mismatch !== 1'b0 || err_cnt !== 8'd0) begin bad++; $display("FAIL rr_nomerge[%0d]: got %b/%0d want 0/0", i, mismatch, err_cnt); end
`endif
            prev_g = exp_g;
            @(negedge clk);
        end
        total++; if (rvalid !== 2'b10) begin bad++; $display("FAIL rr_last_rvalid: got %b want 10", rvalid); end
        idle();
        @(negedge clk);
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL rr_idle: got %b want 00", rvalid); end
    endtask

    task automatic test_back_to_back();
        req = 2'b10; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 32'h30; wdata[1] = 32'hAAAA0001; #1;
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL b2b_gnt1: got %b want 10", gnt); end
        @(negedge clk);
        total++; if (rvalid !== 2'b10) begin bad++; $display("FAIL b2b_rv1: got %b want 10", rvalid); end
        addr[1] = 32'h34; wdata[1] = 32'hBBBBBBBB;
        @(negedge clk);
        total++; if (rvalid !== 2'b10) begin bad++; $display("FAIL b2b_rv2: got %b want 10", rvalid); end
        be[1] = 4'b0011; wdata[1] = 32'h12345555; #1;
        total++; if (ram_be !== 4'b0011) begin bad++; $display("FAIL b2b_be: got %b want 0011", ram_be); end
        @(negedge clk);
        total++; if (rvalid !== 2'b10) begin bad++; $display("FAIL b2b_rv3: got %b want 10", rvalid); end
        req = 2'b01; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h30; #1;
        total++; if (gnt !== 2'b01 || ram_we !== 1'b0) begin bad++; $display("FAIL b2b_rd: got gnt=%b we=%b want 01 0", gnt, ram_we); end
        @(negedge clk);
        total++; if (rvalid !== 2'b01 || rdata !== 32'hAAAA0001) begin bad++; $display("FAIL b2b_rd1: got %b %h want 01 aaaa0001", rvalid, rdata); end
        addr[0] = 32'h34;
        @(negedge clk);
        total++; if (rvalid !== 2'b01 || rdata !== 32'hBBBB5555) begin bad++; $display("FAIL b2b_rd2: got %b %h want 01 bbbb5555", rvalid, rdata); end
        idle();
        @(negedge clk);
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL b2b_idle: got %b want 00", rvalid); end
    endtask

`ifdef LOCKSTEP_MERGE_EN
    task automatic test_merge_match();
        do_reset();
        req = 2'b11; addr[0] = 32'h20; addr[1] = 32'h20; be = '1;
        wdata[0] = 32'h1; wdata[1] = 32'h2; #1;
        total++; if (gnt !== 2'b11) begin bad++; $display("FAIL mm_gnt: got %b want 11", gnt); end
        total++; if (ram_en !== 1'b1 || ram_addr !== 12'h008) begin bad++; $display("FAIL mm_ram: got %b %h want 1 008", ram_en, ram_addr); end
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL mm_mismatch: got %b want 0", mismatch); end
        @(negedge clk);
        total++; if (rvalid !== 2'b11) begin bad++; $display("FAIL mm_rvalid: got %b want 11", rvalid); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL mm_err: got %0d want 0", err_cnt); end
        idle(); #1;
        total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL mm_one_pulse: got %b want 0", ram_en); end
        @(negedge clk);
    endtask

    task automatic test_merge_mismatch();
        req = 2'b11; addr[0] = 32'h20; addr[1] = 32'h20; we = 2'b11; be = '1;
        wdata[0] = 32'h1; wdata[1] = 32'h2; #1;
        total++; if (mismatch !== 1'b1) begin bad++; $display("FAIL mx_pulse: got %b want 1", mismatch); end
        total++; if (gnt !== 2'b01 || ram_wdata !== 32'h1) begin bad++; $display("FAIL mx_first: got %b %h want 01 1", gnt, ram_wdata); end
        @(negedge clk);
        total++; if (err_cnt !== 8'd1 || rvalid !== 2'b01) begin bad++; $display("FAIL mx_cnt: got %0d %b want 1 01", err_cnt, rvalid); end
        req = 2'b10; #1;
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL mx_single: got %b want 0", mismatch); end
        total++; if (gnt !== 2'b10 || ram_en !== 1'b1 || ram_wdata !== 32'h2) begin bad++; $display("FAIL mx_second: got %b %b %h want 10 1 2", gnt, ram_en, ram_wdata); end
        @(negedge clk);
        total++; if (err_cnt !== 8'd1 || rvalid !== 2'b10) begin bad++; $display("FAIL mx_end: got %0d %b want 1 10", err_cnt, rvalid); end
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        req = 2'b11; we = 2'b11; be = '1; addr[0] = 32'h40; addr[1] = 32'h40;
        wdata[0] = 32'h5; wdata[1] = 32'h6;
        repeat (254) @(negedge clk);
        total++; if (err_cnt !== 8'd254) begin bad++; $display("FAIL sat_254: got %0d want 254", err_cnt); end
        @(negedge clk);
        total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL sat_255: got %0d want 255", err_cnt); end
        repeat (45) @(negedge clk);
        total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL sat_hold: got %0d want 255", err_cnt); end
        idle();
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        req = 2'b11; addr[0] = 32'h100; addr[1] = 32'h200; be = '1; #1;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rm_gnt: got %b want 01", gnt); end
        @(negedge clk);
        rst = 1'b1; req = 2'b10; #1;
        total++; if (gnt !== 2'b00 || ram_en !== 1'b0) begin bad++; $display("FAIL rm_abandon: got %b %b want 00 0", gnt, ram_en); end
        @(negedge clk);
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL rm_rvalid: got %b want 00", rvalid); end
        rst = 1'b0; req = 2'b11; #1;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rm_prio: got %b want 01", gnt); end
        @(negedge clk);
        total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL rm_after: got %b want 01", rvalid); end
        idle();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        ram_rdata = 32'h0;
        rst = 1'b1; idle();
        test_reset();
        test_write_read();
        test_round_robin();
        test_back_to_back();
`ifdef LOCKSTEP_MERGE_EN
        test_merge_match();
        test_merge_mismatch();
        test_saturation();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
